ahb_dma_master: RTL and testbench

AHB_DMA_MASTER -- requirements
Module: ahb_dma_master

---
 rtl/ahb_pkg.sv | 30 +++
 rtl/ahb_dma_master.sv | 182 ++++++++++++++++++
 tb/tb_ahb_dma_master.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the DMA master state type.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;
  localparam logic [1:0] HRESP_OKAY    = 2'b00;
  localparam logic [1:0] HRESP_ERROR   = 2'b01;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD_A = 3'd1,
    RD_D = 3'd2,
    WR_A = 3'd3,
    WR_D = 3'd4,
    DONE = 3'd5,
    ERR  = 3'd6
  } dma_state_e;

  // Rebuild a word-aligned byte address from a word index.
  function automatic logic [31:0] word_addr(input logic [29:0] word_idx);
    return {word_idx, 2'b00};
  endfunction

  // Any response other than OKAY terminates the copy.
  function automatic logic resp_is_error(input logic [1:0] resp);
    return (resp != HRESP_OKAY);
  endfunction

endpackage

// File: rtl/ahb_dma_master.sv
// Single-channel AHB-Lite memory-to-memory copy engine.
// Each word is a non-pipelined read (address + data phase) followed by a
// non-pipelined write, so a word costs four cycles with no wait states.
// Source/destination are tracked as word indices; the byte-offset bits of
// the programmed addresses are discarded.
module ahb_dma_master
  import ahb_pkg::*;
#(
  parameter int LEN_W = 16
) (
  input  logic             hclk,
  input  logic             hreset_n,
  input  logic             start,
  input  logic [31:0]      src_addr,
  input  logic [31:0]      dst_addr,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [31:0]      haddr,
  output logic [1:0]       htrans,
  output logic             hwrite,
  output logic [2:0]       hsize,
  output logic [31:0]      hwdata,
  input  logic             hready,
  input  logic [31:0]      hrdata,
  input  logic [1:0]       hresp
);

  localparam logic [LEN_W-1:0] LEN_ZERO = {LEN_W{1'b0}};
  localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1'b1);

  dma_state_e       state_r;
  logic [29:0]      src_r;
  logic [29:0]      dst_r;
  logic [LEN_W-1:0] remaining_r;
  logic [31:0]      data_r;
  logic [31:0]      haddr_r;
  logic [1:0]       htrans_r;
  logic             hwrite_r;
  logic             busy_r;
  logic             done_r;
  logic             err_r;
  logic [29:0]      src_next_s;
  logic [29:0]      dst_next_s;
  logic             unused_addr_lsb_s;

  // Byte-offset bits of the programmed addresses carry no meaning here.
  assign unused_addr_lsb_s = ^{src_addr[1:0], dst_addr[1:0]};

  // Word indices wrap naturally modulo 2^30, i.e. byte addresses modulo 2^32.
  assign src_next_s = src_r + 30'd1;
  assign dst_next_s = dst_r + 30'd1;

  assign busy   = busy_r;
  assign done   = done_r;
  assign err    = err_r;
  assign haddr  = haddr_r;
  assign htrans = htrans_r;
  assign hwrite = hwrite_r;
  assign hsize  = HSIZE_WORD;
  assign hwdata = data_r;

  // Copy FSM with counters; every bus output is registered with the state.
  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) begin
      state_r     <= IDLE;
      src_r       <= 30'd0;
      dst_r       <= 30'd0;
      remaining_r <= LEN_ZERO;
      data_r      <= 32'd0;
      haddr_r     <= 32'd0;
      htrans_r    <= HTRANS_IDLE;
      hwrite_r    <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      // done is a single-cycle pulse unless a terminal state is entered.
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            src_r       <= src_addr[31:2];
            dst_r       <= dst_addr[31:2];
            remaining_r <= len;
            err_r       <= 1'b0;
            busy_r      <= 1'b1;
            if (len == LEN_ZERO) begin
              state_r <= DONE;
              done_r  <= 1'b1;
            end else begin
              state_r  <= RD_A;
              htrans_r <= HTRANS_NONSEQ;
              hwrite_r <= 1'b0;
              haddr_r  <= word_addr(src_addr[31:2]);
            end
          end else begin
            busy_r <= 1'b0;
          end
        end

        RD_A: begin
          if (hready) begin
            state_r  <= RD_D;
            htrans_r <= HTRANS_IDLE;
            hwrite_r <= 1'b0;
          end else begin
            state_r <= RD_A;
          end
        end

        RD_D: begin
          if (resp_is_error(hresp)) begin
            state_r <= ERR;
            err_r   <= 1'b1;
            done_r  <= 1'b1;
          end else if (hready) begin
            data_r   <= hrdata;
            state_r  <= WR_A;
            htrans_r <= HTRANS_NONSEQ;
            hwrite_r <= 1'b1;
            haddr_r  <= word_addr(dst_r);
          end else begin
            state_r <= RD_D;
          end
        end

        WR_A: begin
          if (hready) begin
            state_r  <= WR_D;
            htrans_r <= HTRANS_IDLE;
            hwrite_r <= 1'b0;
          end else begin
            state_r <= WR_A;
          end
        end

        WR_D: begin
          if (resp_is_error(hresp)) begin
            state_r <= ERR;
            err_r   <= 1'b1;
            done_r  <= 1'b1;
          end else if (hready) begin
            src_r       <= src_next_s;
            dst_r       <= dst_next_s;
            remaining_r <= remaining_r - LEN_ONE;
            if (remaining_r == LEN_ONE) begin
              state_r <= DONE;
              done_r  <= 1'b1;
            end else begin
              state_r  <= RD_A;
              htrans_r <= HTRANS_NONSEQ;
              hwrite_r <= 1'b0;
              haddr_r  <= word_addr(src_next_s);
            end
          end else begin
            state_r <= WR_D;
          end
        end

        DONE: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end

        ERR: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end

        default: begin
          state_r  <= IDLE;
          busy_r   <= 1'b0;
          htrans_r <= HTRANS_IDLE;
          hwrite_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_dma_master.sv
// Directed self-checking bench for ahb_dma_master with a zero-wait RAM slave.
module tb_ahb_dma_master;

  logic        hclk;
  logic        hreset_n;
  logic        start;
  logic [31:0] src_addr;
  logic [31:0] dst_addr;
  logic [15:0] len;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [31:0] hwdata;
  logic        hready;
  logic [31:0] hrdata;
  logic [1:0]  hresp;

  int checks;
  int failures;

  ahb_dma_master #(.LEN_W(16)) dut (
    .hclk(hclk), .hreset_n(hreset_n), .start(start),
    .src_addr(src_addr), .dst_addr(dst_addr), .len(len),
    .busy(busy), .done(done), .err(err),
    .haddr(haddr), .htrans(htrans), .hwrite(hwrite), .hsize(hsize),
    .hwdata(hwdata), .hready(hready), .hrdata(hrdata), .hresp(hresp)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  // Slave memory: rom supplies read data, wmem records writes.
  logic [31:0] rom  [0:255];
  logic [31:0] wmem [0:255];
  logic [31:0] rd_log [0:15];
  int nonseq_cnt = 0;
  int rd_cnt = 0;
  int wr_cnt = 0;
  logic       dp_valid;
  logic       dp_write;
  logic [7:0] dp_idx;

  assign hrdata = rom[dp_idx];

  // Slave data-phase tracking.
  always @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) begin
      dp_valid <= 1'b0;
      dp_write <= 1'b0;
      dp_idx   <= 8'd0;
    end else if (hready) begin
      dp_valid <= (htrans == 2'b10);
      dp_write <= hwrite;
      dp_idx   <= haddr[9:2];
    end
  end

  // Bus monitor and write storage.
  always @(posedge hclk) begin
    if (hreset_n && hready) begin
      if (dp_valid && dp_write) begin
        wmem[dp_idx] <= hwdata;
        wr_cnt <= wr_cnt + 1;
      end
      if (htrans == 2'b10) begin
        nonseq_cnt <= nonseq_cnt + 1;
        if (!hwrite) begin
          rd_log[rd_cnt % 16] <= haddr;
          rd_cnt <= rd_cnt + 1;
        end
      end
    end
  end

  // Launch one copy and observe until the done pulse has ended.
  task automatic run_copy(input logic [31:0] s, input logic [31:0] d, input logic [15:0] l,
                          input int stall_cyc, input int stall_len, input int err_cyc,
                          output int done_cyc, output int pulses,
                          output logic [31:0] stall_hw, output logic stall_bad);
    done_cyc  = 0;
    pulses    = 0;
    stall_hw  = 32'd0;
    stall_bad = 1'b0;
    src_addr = s;
    dst_addr = d;
    len      = l;
    start    = 1'b1;
    @(posedge hclk);
    #1 start = 1'b0;
    for (int cyc = 1; cyc <= 100; cyc++) begin
      @(negedge hclk);
      hresp  = (cyc == err_cyc) ? 2'b01 : 2'b00;
      hready = (stall_len > 0 && cyc >= stall_cyc && cyc < stall_cyc + stall_len) ? 1'b0 : 1'b1;
      if (stall_len > 0 && cyc == stall_cyc) stall_hw = hwdata;
      else if (stall_len > 0 && cyc > stall_cyc && cyc <= stall_cyc + stall_len) begin
        if (hwdata !== stall_hw || htrans !== 2'b00) stall_bad = 1'b1;
      end
      if (done === 1'b1) begin
        pulses++;
        if (done_cyc == 0) done_cyc = cyc;
      end else if (done_cyc != 0) begin
        break;
      end
    end
    hready = 1'b1;
    hresp  = 2'b00;
  endtask

  task automatic test_reset();
    checks += 8;
    if (busy !== 1'b0)      begin failures++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    if (done !== 1'b0)      begin failures++; $display("FAIL reset_done got=%0b exp=0", done); end
    if (err !== 1'b0)       begin failures++; $display("FAIL reset_err got=%0b exp=0", err); end
    if (htrans !== 2'b00)   begin failures++; $display("FAIL reset_htrans got=%0b exp=00", htrans); end
    if (hwrite !== 1'b0)    begin failures++; $display("FAIL reset_hwrite got=%0b exp=0", hwrite); end
    if (hsize !== 3'b010)   begin failures++; $display("FAIL reset_hsize got=%0b exp=010", hsize); end
    if (haddr !== 32'd0)    begin failures++; $display("FAIL reset_haddr got=%h exp=0", haddr); end
    if (hwdata !== 32'd0)   begin failures++; $display("FAIL reset_hwdata got=%h exp=0", hwdata); end
  endtask

  task automatic test_copy4();
    int dc, pc, ns0, rd0, wr0;
    logic [31:0] sh;
    logic sb;
    logic [31:0] exp_w [0:3];
    exp_w[0] = 32'hA5A5_0001; exp_w[1] = 32'h5A5A_0002;
    exp_w[2] = 32'hDEAD_BEEF; exp_w[3] = 32'h0123_4567;
    ns0 = nonseq_cnt; rd0 = rd_cnt; wr0 = wr_cnt;
    run_copy(32'h0000_0100, 32'h0000_0200, 16'd4, 0, 0, 0, dc, pc, sh, sb);
    checks += 6;
    if (dc != 17)               begin failures++; $display("FAIL copy4_done_cycle got=%0d exp=17", dc); end
    if (pc != 1)                begin failures++; $display("FAIL copy4_done_pulses got=%0d exp=1", pc); end
    if (nonseq_cnt - ns0 != 8)  begin failures++; $display("FAIL copy4_nonseq got=%0d exp=8", nonseq_cnt - ns0); end
    if (rd_cnt - rd0 != 4)      begin failures++; $display("FAIL copy4_reads got=%0d exp=4", rd_cnt - rd0); end
    if (wr_cnt - wr0 != 4)      begin failures++; $display("FAIL copy4_writes got=%0d exp=4", wr_cnt - wr0); end
    if (busy !== 1'b0)          begin failures++; $display("FAIL copy4_busy got=%0b exp=0", busy); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (wmem[128 + i] !== exp_w[i]) begin
        failures++; $display("FAIL copy4_dst%0d got=%h exp=%h", i, wmem[128 + i], exp_w[i]);
      end
    end
  endtask

  task automatic test_len0();
    int dc, pc, ns0;
    logic [31:0] sh;
    logic sb;
    ns0 = nonseq_cnt;
    run_copy(32'h0000_0100, 32'h0000_0200, 16'd0, 0, 0, 0, dc, pc, sh, sb);
    checks += 3;
    if (dc != 1)                begin failures++; $display("FAIL len0_done_cycle got=%0d exp=1", dc); end
    if (pc != 1)                begin failures++; $display("FAIL len0_done_pulses got=%0d exp=1", pc); end
    if (nonseq_cnt - ns0 != 0)  begin failures++; $display("FAIL len0_nonseq got=%0d exp=0", nonseq_cnt - ns0); end
  endtask

  task automatic test_wait_states();
    int dc, pc;
    logic [31:0] sh;
    logic sb;
    logic [31:0] exp_w [0:2];
    exp_w[0] = 32'h1357_9BDF; exp_w[1] = 32'h2468_ACE0; exp_w[2] = 32'h0F0F_F0F0;
    run_copy(32'h0000_0140, 32'h0000_0240, 16'd3, 8, 3, 0, dc, pc, sh, sb);
    checks += 4;
    if (dc != 16)               begin failures++; $display("FAIL wait_done_cycle got=%0d exp=16", dc); end
    if (pc != 1)                begin failures++; $display("FAIL wait_done_pulses got=%0d exp=1", pc); end
    if (sh !== exp_w[1])        begin failures++; $display("FAIL wait_hwdata got=%h exp=%h", sh, exp_w[1]); end
    if (sb !== 1'b0)            begin failures++; $display("FAIL wait_hold got=%0b exp=0", sb); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (wmem[144 + i] !== exp_w[i]) begin
        failures++; $display("FAIL wait_dst%0d got=%h exp=%h", i, wmem[144 + i], exp_w[i]);
      end
    end
  endtask

  task automatic test_error();
    int dc, pc, ns0, wr0;
    logic [31:0] sh;
    logic sb;
    ns0 = nonseq_cnt; wr0 = wr_cnt;
    run_copy(32'h0000_0100, 32'h0000_0300, 16'd3, 0, 0, 2, dc, pc, sh, sb);
    repeat (3) @(negedge hclk);
    checks += 6;
    if (dc != 3)                begin failures++; $display("FAIL err_done_cycle got=%0d exp=3", dc); end
    if (pc != 1)                begin failures++; $display("FAIL err_done_pulses got=%0d exp=1", pc); end
    if (nonseq_cnt - ns0 != 1)  begin failures++; $display("FAIL err_nonseq got=%0d exp=1", nonseq_cnt - ns0); end
    if (wr_cnt - wr0 != 0)      begin failures++; $display("FAIL err_writes got=%0d exp=0", wr_cnt - wr0); end
    if (err !== 1'b1)           begin failures++; $display("FAIL err_flag got=%0b exp=1", err); end
    if (busy !== 1'b0)          begin failures++; $display("FAIL err_busy got=%0b exp=0", busy); end
  endtask

  task automatic test_wrap();
    int dc, pc, rd0;
    logic [31:0] sh;
    logic sb;
    rd0 = rd_cnt;
    run_copy(32'hFFFF_FFFC, 32'h0000_0040, 16'd2, 0, 0, 0, dc, pc, sh, sb);
    checks += 6;
    if (dc != 9)                            begin failures++; $display("FAIL wrap_done_cycle got=%0d exp=9", dc); end
    if (rd_log[rd0 % 16] !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_rd0 got=%h exp=fffffffc", rd_log[rd0 % 16]); end
    if (rd_log[(rd0 + 1) % 16] !== 32'd0)   begin failures++; $display("FAIL wrap_rd1 got=%h exp=00000000", rd_log[(rd0 + 1) % 16]); end
    if (wmem[16] !== 32'hCAFE_F00D)         begin failures++; $display("FAIL wrap_dst0 got=%h exp=cafef00d", wmem[16]); end
    if (wmem[17] !== 32'h8000_0001)         begin failures++; $display("FAIL wrap_dst1 got=%h exp=80000001", wmem[17]); end
    if (err !== 1'b0)                       begin failures++; $display("FAIL wrap_err_cleared got=%0b exp=0", err); end
  endtask

  task automatic test_reset_mid_copy();
    int dc, pc, ns0;
    logic [31:0] sh;
    logic sb;
    logic [31:0] exp_w [0:3];
    exp_w[0] = 32'h0BAD_F00D; exp_w[1] = 32'h1234_5678;
    exp_w[2] = 32'h8765_4321; exp_w[3] = 32'hFEED_FACE;
    src_addr = 32'h0000_0300; dst_addr = 32'h0000_0380; len = 16'd4;
    start = 1'b1;
    @(posedge hclk);
    #1 start = 1'b0;
    repeat (3) @(negedge hclk);
    checks += 1;
    if (htrans !== 2'b10 || hwrite !== 1'b1) begin
      failures++; $display("FAIL rstmid_in_wr_a got=%0b/%0b exp=10/1", htrans, hwrite);
    end
    hreset_n = 1'b0;
    #1;
    checks += 3;
    if (htrans !== 2'b00) begin failures++; $display("FAIL rstmid_htrans got=%0b exp=00", htrans); end
    if (busy !== 1'b0)    begin failures++; $display("FAIL rstmid_busy got=%0b exp=0", busy); end
    if (hwrite !== 1'b0)  begin failures++; $display("FAIL rstmid_hwrite got=%0b exp=0", hwrite); end
    repeat (2) @(negedge hclk);
    hreset_n = 1'b1;
    ns0 = nonseq_cnt;
    repeat (10) @(negedge hclk);
    checks += 2;
    if (nonseq_cnt - ns0 != 0) begin failures++; $display("FAIL rstmid_no_resume got=%0d exp=0", nonseq_cnt - ns0); end
    if (busy !== 1'b0)         begin failures++; $display("FAIL rstmid_idle_busy got=%0b exp=0", busy); end
    run_copy(32'h0000_0300, 32'h0000_0380, 16'd4, 0, 0, 0, dc, pc, sh, sb);
    checks += 1;
    if (dc != 17) begin failures++; $display("FAIL rstmid_restart_done got=%0d exp=17", dc); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (wmem[224 + i] !== exp_w[i]) begin
        failures++; $display("FAIL rstmid_dst%0d got=%h exp=%h", i, wmem[224 + i], exp_w[i]);
      end
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    for (int i = 0; i < 256; i++) rom[i] = 32'd0;
    rom[64]  = 32'hA5A5_0001; rom[65]  = 32'h5A5A_0002;
    rom[66]  = 32'hDEAD_BEEF; rom[67]  = 32'h0123_4567;
    rom[80]  = 32'h1357_9BDF; rom[81]  = 32'h2468_ACE0; rom[82] = 32'h0F0F_F0F0;
    rom[192] = 32'h0BAD_F00D; rom[193] = 32'h1234_5678;
    rom[194] = 32'h8765_4321; rom[195] = 32'hFEED_FACE;
    rom[255] = 32'hCAFE_F00D; rom[0]   = 32'h8000_0001;
    hreset_n = 1'b0;
    start    = 1'b0;
    src_addr = 32'd0;
    dst_addr = 32'd0;
    len      = 16'd0;
    hready   = 1'b1;
    hresp    = 2'b00;
    repeat (2) @(negedge hclk);
    test_reset();
    hreset_n = 1'b1;
    @(negedge hclk);
    test_reset();
    test_copy4();
    test_len0();
    test_wait_states();
    test_error();
    test_wrap();
    test_reset_mid_copy();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
